// File: rtl/ram_rd_check.sv
// ram_rd_check: read-back checker for a single-port RAM sweep test.
// It snoops the stimulus control bus and the RAM read data. Each word read
// back is compared with its own address, zero-extended to DATA_W, because
// the stimulus writes data = address. Per-word, per-sweep and sticky results
// are reported for LED/ILA observation.
//
// Ports:
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   ram_en, ram_we, addr  RAM control bus snooped from the stimulus
//   ram_rd_data           RAM read data, RD_LATENCY cycles after the request
//   chk_valid, chk_err    one-cycle compare-retired pulse; chk_err = mismatch
//   err_cnt               saturating mismatch count
//   sweep_done, sweep_ok  end-of-sweep pulse; sweep_ok holds until next done
//   pass_cnt              wrapping count of passing sweeps
//   error_flag            sticky error indication
//   first_err_addr/_data  first mismatch capture (RAM_CHK_FIRST_ERR_EN),
//                         otherwise tied to zero
//
// Optional feature macro: RAM_CHK_FIRST_ERR_EN
module ram_rd_check #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ram_en,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              chk_valid,
  output logic              chk_err,
  output logic [15:0]       err_cnt,
  output logic              sweep_done,
  output logic              sweep_ok,
  output logic [15:0]       pass_cnt,
  output logic              error_flag,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned SW_W  = ADDR_W + 1;
  localparam logic [SW_W-1:0] SW_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [SW_W-1:0] SW_MAX  = '1;
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CLOSE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   close_cnt_q, close_cnt_d;

  // Read pipeline of {valid, addr}; index RD_LATENCY-1 is the tail.
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [ADDR_W-1:0]     pa_q [RD_LATENCY];
  logic [ADDR_W-1:0]     pa_d [RD_LATENCY];

  logic [SW_W-1:0]    sw_rd_q, sw_rd_d;
  logic               sw_err_q, sw_err_d;

  logic               chk_valid_q, chk_valid_d;
  logic               chk_err_q, chk_err_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic               sweep_done_q, sweep_done_d;
  logic               sweep_ok_q, sweep_ok_d;
  logic [15:0]        pass_cnt_q, pass_cnt_d;
  logic               error_flag_q, error_flag_d;

  logic               wr_req_c;
  logic               rd_req_c;
  logic               load_c;
  logic               clr_sweep_c;
  logic               close_evt_c;
  logic               cmp_c;
  logic               mis_c;
  logic               sweep_pass_c;
  logic [DATA_W-1:0]  exp_c;

  assign wr_req_c = ram_en & ram_we;
  assign rd_req_c = ram_en & ~ram_we;

  // Compare at the pipeline tail against the address pattern.
  assign exp_c        = DATA_W'(pa_q[RD_LATENCY-1]);
  assign cmp_c        = pv_q[RD_LATENCY-1];
  assign mis_c        = cmp_c & (ram_rd_data != exp_c);
  assign sweep_pass_c = (sw_rd_q == SW_FULL) & ~sw_err_q;

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      close_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      close_cnt_q <= close_cnt_d;
    end
  end

  // FSM next state; decides which reads are loaded and when a sweep closes.
  always_comb begin
    state_d     = state_q;
    close_cnt_d = close_cnt_q;
    load_c      = 1'b0;
    clr_sweep_c = 1'b0;
    close_evt_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_req_c) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (rd_req_c) begin
          state_d     = S_READ;
          load_c      = 1'b1;
          clr_sweep_c = 1'b1;
        end
      end
      S_READ: begin
        if (wr_req_c) begin
          state_d     = S_CLOSE;
          close_cnt_d = '0;
        end else if (rd_req_c) begin
          load_c = 1'b1;
        end
      end
      S_CLOSE: begin
        // Hold for RD_LATENCY cycles so every in-flight read retires.
        if (close_cnt_q == CLOSE_LAST) begin
          state_d     = S_WRITE;
          close_evt_c = 1'b1;
        end else begin
          close_cnt_d = close_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next state: pipeline shift, per-sweep and global statistics.
  always_comb begin
    pv_d[0] = load_c;
    pa_d[0] = load_c ? addr : '0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end

    sw_rd_d = sw_rd_q;
    if (cmp_c && (sw_rd_q != SW_MAX)) sw_rd_d = sw_rd_q + SW_W'(1);
    sw_err_d = sw_err_q | mis_c;
    if (clr_sweep_c) begin
      sw_rd_d  = '0;
      sw_err_d = 1'b0;
    end

    chk_valid_d = cmp_c;
    chk_err_d   = mis_c;

    err_cnt_d = err_cnt_q;
    if (mis_c && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;

    sweep_done_d = close_evt_c;
    sweep_ok_d   = close_evt_c ? sweep_pass_c : sweep_ok_q;

    pass_cnt_d = pass_cnt_q;
    if (close_evt_c && sweep_pass_c) pass_cnt_d = pass_cnt_q + 16'd1;

    error_flag_d = error_flag_q | mis_c | (close_evt_c & ~sweep_pass_c);
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pv_q         <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pa_q[i] <= '0;
      sw_rd_q      <= '0;
      sw_err_q     <= 1'b0;
      chk_valid_q  <= 1'b0;
      chk_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      sweep_done_q <= 1'b0;
      sweep_ok_q   <= 1'b0;
      pass_cnt_q   <= '0;
      error_flag_q <= 1'b0;
    end else begin
      pv_q         <= pv_d;
      for (int i = 0; i < RD_LATENCY; i++) pa_q[i] <= pa_d[i];
      sw_rd_q      <= sw_rd_d;
      sw_err_q     <= sw_err_d;
      chk_valid_q  <= chk_valid_d;
      chk_err_q    <= chk_err_d;
      err_cnt_q    <= err_cnt_d;
      sweep_done_q <= sweep_done_d;
      sweep_ok_q   <= sweep_ok_d;
      pass_cnt_q   <= pass_cnt_d;
      error_flag_q <= error_flag_d;
    end
  end

  assign chk_valid  = chk_valid_q;
  assign chk_err    = chk_err_q;
  assign err_cnt    = err_cnt_q;
  assign sweep_done = sweep_done_q;
  assign sweep_ok   = sweep_ok_q;
  assign pass_cnt   = pass_cnt_q;
  assign error_flag = error_flag_q;

`ifdef RAM_CHK_FIRST_ERR_EN
  logic              fe_seen_q;
  logic [ADDR_W-1:0] fe_addr_q;
  logic [DATA_W-1:0] fe_data_q;

  // Capture only the first mismatch after reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fe_seen_q <= 1'b0;
      fe_addr_q <= '0;
      fe_data_q <= '0;
    end else if (mis_c && !fe_seen_q) begin
      fe_seen_q <= 1'b1;
      fe_addr_q <= pa_q[RD_LATENCY-1];
      fe_data_q <= ram_rd_data;
    end
  end

  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_ram_rd_check.sv
// Directed bench for ram_rd_check: two instances (RD_LATENCY 1 and 3) share
// one stimulus bus; each sees its own behavioural RAM with matching latency.
module tb_ram_rd_check;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, we;
  logic [AW-1:0] addr;
  logic          corrupt;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_now, rd1, ra, rb, rd3;

  logic          v1, e1, sd1, ok1, ef1;
  logic [15:0]   ec1, pc1;
  logic [AW-1:0] fa1;
  logic [DW-1:0] fd1;
  logic          v3, e3, sd3, ok3, ef3;
  logic [15:0]   ec3, pc3;
  logic [AW-1:0] fa3;
  logic [DW-1:0] fd3;

  int nchk = 0;
  int npass = 0;
  int cyc = 0;
  int nv1, ne1, nd1, fv1, dc1;
  int nv3, ne3, nd3, fv3, dc3;
  logic okd1, okd3;
  int rdc, wcyc;

  always #5 clk = ~clk;

  // RAM model: write data = addr, optional corruption of word 5.
  assign rd_now = (en && !we) ? ((corrupt && addr == AW'(5)) ? 8'hA5 : mem[addr]) : 8'h00;
  always @(posedge clk) begin
    if (en && we) mem[addr] <= DW'(addr);
    rd1 <= rd_now;
    ra  <= rd_now;
    rb  <= ra;
    rd3 <= rb;
  end

  ram_rd_check #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst), .ram_en(en), .ram_we(we), .addr(addr),
    .ram_rd_data(rd1), .chk_valid(v1), .chk_err(e1), .err_cnt(ec1),
    .sweep_done(sd1), .sweep_ok(ok1), .pass_cnt(pc1), .error_flag(ef1),
    .first_err_addr(fa1), .first_err_data(fd1));

  ram_rd_check #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
    .sys_clk(clk), .sys_rst(rst), .ram_en(en), .ram_we(we), .addr(addr),
    .ram_rd_data(rd3), .chk_valid(v3), .chk_err(e3), .err_cnt(ec3),
    .sweep_done(sd3), .sweep_ok(ok3), .pass_cnt(pc3), .error_flag(ef3),
    .first_err_addr(fa3), .first_err_data(fd3));

  // One clock; outputs observed 1 time unit after the edge and tallied.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (v1) begin nv1++; if (nv1 == 1) fv1 = cyc; end
    if (v1 && e1) ne1++;
    if (sd1) begin nd1++; dc1 = cyc; okd1 = ok1; end
    if (v3) begin nv3++; if (nv3 == 1) fv3 = cyc; end
    if (v3 && e3) ne3++;
    if (sd3) begin nd3++; dc3 = cyc; okd3 = ok3; end
  endtask

  task automatic clr_mon();
    nv1 = 0; ne1 = 0; nd1 = 0; fv1 = 0; dc1 = 0; okd1 = 1'bx;
    nv3 = 0; ne3 = 0; nd3 = 0; fv3 = 0; dc3 = 0; okd3 = 1'bx;
  endtask

  task automatic do_writes(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b1; we = 1'b1; addr = AW'(i);
      tick();
    end
  endtask

  task automatic do_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      en = 1'b1; we = 1'b0; addr = AW'(i);
      tick();
      if (i == lo) rdc = cyc;
    end
  endtask

  // Write request closes the sweep, then the bus idles.
  task automatic close_sweep();
    en = 1'b1; we = 1'b1; addr = '0;
    tick();
    wcyc = cyc;
    en = 1'b0; we = 1'b0;
    repeat (6) tick();
  endtask

  task automatic full_sweep(input int n_reads);
    clr_mon();
    do_writes(32);
    do_reads(0, n_reads - 1);
    close_sweep();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; corrupt = 1'b0;
    repeat (3) tick();
    nchk++; if ({v1, e1, ec1, sd1, ok1, pc1, ef1, fa1, fd1} !== 50'd0)
      $display("FAIL reset_outs_l1 got %h exp 0", {v1, e1, ec1, sd1, ok1, pc1, ef1, fa1, fd1}); else npass++;
    nchk++; if ({v3, e3, ec3, sd3, ok3, pc3, ef3, fa3, fd3} !== 50'd0)
      $display("FAIL reset_outs_l3 got %h exp 0", {v3, e3, ec3, sd3, ok3, pc3, ef3, fa3, fd3}); else npass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean();
    full_sweep(32);
    nchk++; if (nv1 !== 32) $display("FAIL clean_nvalid_l1 got %0d exp 32", nv1); else npass++;
    nchk++; if (nv3 !== 32) $display("FAIL clean_nvalid_l3 got %0d exp 32", nv3); else npass++;
    nchk++; if (ne1 + ne3 !== 0) $display("FAIL clean_nerr got %0d exp 0", ne1 + ne3); else npass++;
    nchk++; if (fv1 - rdc !== 1) $display("FAIL clean_lat_l1 got %0d exp 1", fv1 - rdc); else npass++;
    nchk++; if (fv3 - rdc !== 3) $display("FAIL clean_lat_l3 got %0d exp 3", fv3 - rdc); else npass++;
    nchk++; if (nd1 !== 1 || okd1 !== 1'b1) $display("FAIL clean_done_l1 got n=%0d ok=%b exp n=1 ok=1", nd1, okd1); else npass++;
    nchk++; if (nd3 !== 1 || okd3 !== 1'b1) $display("FAIL clean_done_l3 got n=%0d ok=%b exp n=1 ok=1", nd3, okd3); else npass++;
    nchk++; if (dc1 - wcyc !== 1) $display("FAIL clean_done_time_l1 got %0d exp 1", dc1 - wcyc); else npass++;
    nchk++; if (pc1 !== 16'd1 || pc3 !== 16'd1) $display("FAIL clean_pass_cnt got %0d/%0d exp 1/1", pc1, pc3); else npass++;
    nchk++; if (ec1 !== 16'd0 || ec3 !== 16'd0 || ef1 !== 1'b0 || ef3 !== 1'b0)
      $display("FAIL clean_err_state got ec=%0d/%0d ef=%b/%b exp 0", ec1, ec3, ef1, ef3); else npass++;
    nchk++; if (ok1 !== 1'b1 || ok3 !== 1'b1) $display("FAIL clean_ok_held got %b/%b exp 1/1", ok1, ok3); else npass++;
  endtask

  task automatic test_corrupt();
    corrupt = 1'b1;
    full_sweep(32);
    corrupt = 1'b0;
    nchk++; if (ne1 !== 1 || ne3 !== 1) $display("FAIL corrupt_nerr got %0d/%0d exp 1/1", ne1, ne3); else npass++;
    nchk++; if (ec1 !== 16'd1 || ec3 !== 16'd1) $display("FAIL corrupt_err_cnt got %0d/%0d exp 1/1", ec1, ec3); else npass++;
    nchk++; if (ef1 !== 1'b1 || ef3 !== 1'b1) $display("FAIL corrupt_error_flag got %b/%b exp 1/1", ef1, ef3); else npass++;
    nchk++; if (okd1 !== 1'b0 || okd3 !== 1'b0) $display("FAIL corrupt_sweep_ok got %b/%b exp 0/0", okd1, okd3); else npass++;
    nchk++; if (pc1 !== 16'd1 || pc3 !== 16'd1) $display("FAIL corrupt_pass_cnt got %0d/%0d exp 1/1", pc1, pc3); else npass++;
`ifdef RAM_CHK_FIRST_ERR_EN
    nchk++; if (fa1 !== 5'd5 || fd1 !== 8'hA5 || fa3 !== 5'd5 || fd3 !== 8'hA5)
      $display("FAIL corrupt_first_err got %0d/%h %0d/%h exp 5/a5", fa1, fd1, fa3, fd3); else npass++;
`else
    nchk++; if (fa1 !== '0 || fd1 !== '0 || fa3 !== '0 || fd3 !== '0)
      $display("FAIL corrupt_first_err_tied got %0d/%h %0d/%h exp 0/00", fa1, fd1, fa3, fd3); else npass++;
`endif
  endtask

  task automatic test_back_to_back();
    full_sweep(32);
    nchk++; if (nv3 !== 32 || ne3 !== 0) $display("FAIL b2b_l3_compares got %0d err %0d exp 32 err 0", nv3, ne3); else npass++;
    nchk++; if (dc3 - wcyc !== 3 || okd3 !== 1'b1) $display("FAIL b2b_l3_done got dt=%0d ok=%b exp dt=3 ok=1", dc3 - wcyc, okd3); else npass++;
    nchk++; if (pc1 !== 16'd2 || pc3 !== 16'd2) $display("FAIL b2b_pass_cnt got %0d/%0d exp 2/2", pc1, pc3); else npass++;
    nchk++; if (ef1 !== 1'b1 || ec3 !== 16'd1) $display("FAIL b2b_sticky got ef=%b ec=%0d exp 1/1", ef1, ec3); else npass++;
  endtask

  task automatic test_reset_mid_read();
    clr_mon();
    do_writes(32);
    do_reads(0, 17);
    nchk++; if (v1 !== 1'b1 || v3 !== 1'b1) $display("FAIL midrst_active got %b/%b exp 1/1", v1, v3); else npass++;
    rst = 1'b1;
    #1;
    nchk++; if ({v1, e1, ec1, sd1, ok1, pc1, ef1, fa1, fd1} !== 50'd0)
      $display("FAIL midrst_outs_l1 got %h exp 0", {v1, e1, ec1, sd1, ok1, pc1, ef1, fa1, fd1}); else npass++;
    nchk++; if ({v3, e3, ec3, sd3, ok3, pc3, ef3, fa3, fd3} !== 50'd0)
      $display("FAIL midrst_outs_l3 got %h exp 0", {v3, e3, ec3, sd3, ok3, pc3, ef3, fa3, fd3}); else npass++;
    en = 1'b0; we = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    full_sweep(32);
    nchk++; if (pc1 !== 16'd1 || pc3 !== 16'd1) $display("FAIL midrst_pass_cnt got %0d/%0d exp 1/1", pc1, pc3); else npass++;
    nchk++; if (nv1 !== 32 || nv3 !== 32 || okd1 !== 1'b1 || okd3 !== 1'b1)
      $display("FAIL midrst_sweep got %0d/%0d ok %b/%b exp 32/32 ok 1/1", nv1, nv3, okd1, okd3); else npass++;
  endtask

  task automatic test_short();
    full_sweep(31);
    nchk++; if (nv1 !== 31 || nv3 !== 31) $display("FAIL short_nvalid got %0d/%0d exp 31/31", nv1, nv3); else npass++;
    nchk++; if (nd1 !== 1 || okd1 !== 1'b0 || nd3 !== 1 || okd3 !== 1'b0)
      $display("FAIL short_done got %0d/%b %0d/%b exp 1/0 1/0", nd1, okd1, nd3, okd3); else npass++;
    nchk++; if (ef1 !== 1'b1 || ef3 !== 1'b1 || ec1 !== 16'd0 || ec3 !== 16'd0)
      $display("FAIL short_flags got ef=%b/%b ec=%0d/%0d exp ef=1/1 ec=0/0", ef1, ef3, ec1, ec3); else npass++;
    nchk++; if (pc1 !== 16'd1 || pc3 !== 16'd1) $display("FAIL short_pass_cnt got %0d/%0d exp 1/1", pc1, pc3); else npass++;
  endtask

  task automatic test_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    repeat (3) full_sweep(32);
    nchk++; if (pc1 !== 16'd3 || pc3 !== 16'd3) $display("FAIL idle_pass_cnt got %0d/%0d exp 3/3", pc1, pc3); else npass++;
    clr_mon();
    en = 1'b0; we = 1'b0;
    repeat (10) tick();
    nchk++; if (nv1 + nv3 + nd1 + nd3 !== 0) $display("FAIL idle_activity got %0d exp 0", nv1 + nv3 + nd1 + nd3); else npass++;
    nchk++; if (pc1 !== 16'd3 || pc3 !== 16'd3) $display("FAIL idle_pass_hold got %0d/%0d exp 3/3", pc1, pc3); else npass++;
    full_sweep(32);
    nchk++; if (pc1 !== 16'd4 || pc3 !== 16'd4 || ef1 !== 1'b0 || ef3 !== 1'b0)
      $display("FAIL idle_resume got %0d/%0d ef %b/%b exp 4/4 ef 0/0", pc1, pc3, ef1, ef3); else npass++;
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_clean();
    test_corrupt();
    test_back_to_back();
    test_reset_mid_read();
    test_short();
    test_idle();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
